// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter: sizes, FSM state
// type and the round-robin winner search.
package mux8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit scanning start, start+1, ... modulo 8.
    // The loop runs from the far end so the closest set bit is the last one written.
    function automatic logic [SEL_W:0] rrPick(input logic [N_REQ-1:0] req,
                                              input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux8.sv
// Plain 8:1 combinational bit mux used by the arbiter data path.
module mux8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic             dout
);

    assign dout = din[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// 8-requester round-robin arbiter driving an 8:1 mux with a registered output.
// Hold timeout (forced release after MAX_HOLD cycles) is built only with MUX8_ARB_TIMEOUT_EN.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    input  logic [N_REQ-1:0] IN,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SEL,
    output logic             BUSY,
    output logic             OUT
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_badHold
        $error("mux8_rr_arbiter: MAX_HOLD must be within 2..256");
    end

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             muxOut;
    logic [N_REQ-1:0] others;
    logic [SEL_W:0]   idlePick;
    logic [SEL_W:0]   relPick;
    logic             forceRel;
    logic             doRelease;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] hcnt;
`endif

    mux8 u_mux (
        .din  (IN),
        .sel  (SEL),
        .dout (muxOut)
    );

    // The holder is masked out of the release rescan so it cannot immediately re-win.
    always_comb begin
        others    = REQ & ~(N_REQ'(1) << SEL);
        idlePick  = rrPick(REQ, ptr);
        relPick   = rrPick(others, SEL + SEL_W'(1));
`ifdef MUX8_ARB_TIMEOUT_EN
        forceRel  = (hcnt == HOLD_LAST) && (|others);
`else
        forceRel  = 1'b0;
`endif
        doRelease = !REQ[SEL] || forceRel;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            GNT   <= '0;
            SEL   <= '0;
            BUSY  <= 1'b0;
            OUT   <= 1'b0;
            ptr   <= '0;
`ifdef MUX8_ARB_TIMEOUT_EN
            hcnt  <= '0;
`endif
        end else begin
            if (BUSY) begin
                OUT <= muxOut;
            end
            case (state)
                IDLE: begin
                    if (idlePick[SEL_W]) begin
                        state <= GRANT;
                        GNT   <= N_REQ'(1) << idlePick[SEL_W-1:0];
                        SEL   <= idlePick[SEL_W-1:0];
                        BUSY  <= 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
                        hcnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (doRelease) begin
                        ptr <= SEL + SEL_W'(1);
                        if (relPick[SEL_W]) begin
                            GNT  <= N_REQ'(1) << relPick[SEL_W-1:0];
                            SEL  <= relPick[SEL_W-1:0];
`ifdef MUX8_ARB_TIMEOUT_EN
                            hcnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            GNT   <= '0;
                            BUSY  <= 1'b0;
                        end
                    end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
                        if (hcnt != HOLD_LAST) begin
                            hcnt <= hcnt + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table through a
// scoreboard queue, then a long random run checking grant invariants and fairness.
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] REQ;
    logic [7:0] IN;
    logic [7:0] GNT;
    logic [2:0] SEL;
    logic       BUSY;
    logic       OUT;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       rstn;
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       dout;
        logic       chkSel;
    } vec_t;

    vec_t tbl[$];
    vec_t expq[$];

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .IN    (IN),
        .GNT   (GNT),
        .SEL   (SEL),
        .BUSY  (BUSY),
        .OUT   (OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic rstn, input logic [7:0] req, input logic [7:0] din,
                          input logic [7:0] gnt, input logic [2:0] sel, input logic busy,
                          input logic dout, input logic chkSel);
        vec_t v;
        v.rstn = rstn; v.req = req; v.din = din; v.gnt = gnt;
        v.sel = sel; v.busy = busy; v.dout = dout; v.chkSel = chkSel;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        RST_N = v.rstn;
        REQ   = v.req;
        IN    = v.din;
        expq.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (expq.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue, want one entry", idx);
            return;
        end
        e = expq.pop_front();
        vectors++;
        if (GNT !== e.gnt) begin
            miscompares++;
            $display("[TB] FAIL vec%0d gnt: got %h want %h", idx, GNT, e.gnt);
        end
        if (e.chkSel && SEL !== e.sel) begin
            miscompares++;
            $display("[TB] FAIL vec%0d sel: got %0d want %0d", idx, SEL, e.sel);
        end
        if (BUSY !== e.busy) begin
            miscompares++;
            $display("[TB] FAIL vec%0d busy: got %b want %b", idx, BUSY, e.busy);
        end
        if (OUT !== e.dout) begin
            miscompares++;
            $display("[TB] FAIL vec%0d out: got %b want %b", idx, OUT, e.dout);
        end
    endtask

    // Drive on the falling edge, let one rising edge act, compare on the next falling edge.
    task automatic runVec(input vec_t v, input int idx);
        applyStimulus(v);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput(idx);
    endtask

    initial begin
        logic [7:0] rq;
        logic [7:0] g;
        logic [7:0] prevGnt;
        int holdLeft[8];
        int waitCnt[8];
        int holder;
        int base;
        bit newGrant;

        RST_N = 1'b0;
        REQ   = 8'h00;
        IN    = 8'h00;

        // Reset, then ten idle cycles with nothing requested.
        addVec(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        addVec(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        for (int i = 0; i < 10; i++) addVec(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 1);
        // Two requesters from PTR=0, data path, then back-to-back handover 2 -> 5.
        addVec(1, 8'h24, 8'h00, 8'h04, 3'd2, 1, 0, 1);
        addVec(1, 8'h24, 8'h04, 8'h04, 3'd2, 1, 1, 1);
        addVec(1, 8'h20, 8'h04, 8'h20, 3'd5, 1, 1, 1);
        addVec(1, 8'h20, 8'h00, 8'h20, 3'd5, 1, 0, 1);
        addVec(1, 8'h00, 8'h00, 8'h00, 3'd5, 0, 0, 0);
        addVec(1, 8'h40, 8'h00, 8'h40, 3'd6, 1, 0, 1);
        addVec(1, 8'h00, 8'h00, 8'h00, 3'd6, 0, 0, 0);
        // PTR=7 now: requester 7 wins first, release wraps to 0, then PTR=1 picks 1 from 8'h03.
        addVec(1, 8'h81, 8'h00, 8'h80, 3'd7, 1, 0, 1);
        addVec(1, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1, 1);
        addVec(1, 8'h01, 8'h00, 8'h01, 3'd0, 1, 0, 1);
        addVec(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        addVec(1, 8'h03, 8'h00, 8'h02, 3'd1, 1, 0, 1);
        addVec(1, 8'h00, 8'h00, 8'h00, 3'd1, 0, 0, 0);
        // Reset in the middle of a grant clears everything; PTR restarts at 0.
        addVec(1, 8'h04, 8'h04, 8'h04, 3'd2, 1, 0, 1);
        addVec(1, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1);
        addVec(0, 8'h04, 8'h04, 8'h00, 3'd0, 0, 0, 1);
        addVec(1, 8'h03, 8'h00, 8'h01, 3'd0, 1, 0, 1);
        addVec(1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);

        @(negedge CLK);
        for (int i = 0; i < tbl.size(); i++) runVec(tbl[i], i);
        base = tbl.size();

        // Two requesters held from PTR=1: alternate every 4 cycles only with the timeout built in.
        for (int k = 0; k < 12; k++) begin
            vec_t v;
            holder = (TIMEOUT && ((k / 4) % 2 == 1)) ? 0 : 1;
            v = '{1'b1, 8'h03, 8'h00, 8'(1 << holder), 3'(holder), 1'b1, 1'b0, 1'b1};
            runVec(v, base + k);
        end
        runVec('{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}, base + 12);
        // A sole requester is never released.
        for (int k = 0; k < 20; k++) begin
            runVec('{1'b1, 8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1}, base + 13 + k);
        end
        runVec('{1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}, base + 33);

        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d leftover entries, want 0", expq.size());
        end

        // Random requesters that hold until granted, then keep the grant for a short while.
        rq = 8'h00;
        prevGnt = GNT;
        for (int i = 0; i < 8; i++) begin
            holdLeft[i] = 0;
            waitCnt[i]  = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            REQ = rq;
            IN  = 8'($urandom);
            @(posedge CLK);
            @(negedge CLK);
            g = GNT;
            vectors++;
            if ((g & (g - 8'd1)) != 8'h00) begin
                miscompares++;
                $display("[TB] FAIL rand%0d onehot: got gnt %h want one-hot or zero", c, g);
            end
            if (g != 8'h00 && g != (8'h01 << SEL)) begin
                miscompares++;
                $display("[TB] FAIL rand%0d gnt/sel: got gnt %h sel %0d want gnt %h", c, g, SEL, 8'h01 << SEL);
            end
            if (g != 8'h00 && !BUSY) begin
                miscompares++;
                $display("[TB] FAIL rand%0d busy: got %b want 1", c, BUSY);
            end
            newGrant = (g != 8'h00) && (g != prevGnt);
            for (int i = 0; i < 8; i++) begin
                if (g[i] || !rq[i]) begin
                    waitCnt[i] = 0;
                end else if (newGrant) begin
                    waitCnt[i]++;
                    if (waitCnt[i] > 7) begin
                        miscompares++;
                        $display("[TB] FAIL rand%0d starve%0d: got %0d grants to others, want at most 7", c, i, waitCnt[i]);
                        waitCnt[i] = 0;
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (g[i]) begin
                    if (holdLeft[i] == 0) rq[i] = 1'b0;
                    else holdLeft[i]--;
                end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
                    rq[i] = 1'b1;
                    holdLeft[i] = $urandom_range(0, 5);
                end
            end
            prevGnt = g;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
